vram_arbiter: RTL

//  Shares one single-port synchronous screen RAM between two requesters:
//  - display pixel fetch from paint_screen (hard real-time);
//  - CPU read/write port (best effort).

---
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its display, CPU and RAM neighbours.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8
) ();
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output disp_valid, disp_data, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  disp_valid, disp_data, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port screen RAM arbiter: display fetch has priority, CPU gets best-effort slots
// with a starvation bound. One RAM access per cycle, all outputs registered.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic           clk,
    input  logic           rst,
    vram_arbiter_if.master bus
);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead0, StRead1, StHold} cpu_st_e;

    cpu_st_e           st_q, st_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              disp_rd0_q, disp_rd0_d;
    logic              disp_rd1_q, disp_rd1_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_elig, force_cpu, cpu_issue;

    always_comb begin
        cpu_elig  = bus.cpu_req && (st_q == StIdle);
        // Forcing is blocked while pend is occupied so a deferred fetch is never overwritten.
        force_cpu = cpu_elig && !pend_v_q && (wait_cnt_q >= CntW'(STARVE_LIMIT));

        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        disp_rd0_d  = 1'b0;
        cpu_issue   = 1'b0;

        if (pend_v_q) begin
            mem_en_d    = 1'b1;
            mem_addr_d  = pend_addr_q;
            disp_rd0_d  = 1'b1;
            pend_v_d    = bus.disp_req;
            if (bus.disp_req) begin
                pend_addr_d = bus.disp_addr;
            end
        end else if (bus.disp_req && !force_cpu) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.disp_addr;
            disp_rd0_d = 1'b1;
        end else if (cpu_elig) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            cpu_issue   = 1'b1;
            if (bus.disp_req) begin
                pend_v_d    = 1'b1;
                pend_addr_d = bus.disp_addr;
            end
        end

        if (!bus.cpu_req || cpu_issue) begin
            wait_cnt_d = '0;
        end else if ((st_q == StIdle) && (wait_cnt_q < CntW'(STARVE_LIMIT))) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        st_d        = st_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        unique case (st_q)
            StIdle: begin
                if (cpu_issue) begin
                    st_d = bus.cpu_we ? StWrite : StRead0;
                end
            end
            StWrite: begin
                cpu_ack_d = 1'b1;
                st_d      = StHold;
            end
            StRead0: st_d = StRead1;
            StRead1: begin
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = bus.mem_rdata;
                st_d        = StHold;
            end
            StHold:  st_d = StIdle;
            default: st_d = StIdle;
        endcase

        // Display read tag follows the RAM pipeline: issue, data on the bus, registered out.
        disp_rd1_d   = disp_rd0_q;
        disp_valid_d = disp_rd1_q;
        disp_data_d  = disp_rd1_q ? bus.mem_rdata : disp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= StIdle;
            pend_v_q     <= 1'b0;
            pend_addr_q  <= '0;
            wait_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            disp_rd0_q   <= 1'b0;
            disp_rd1_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            st_q         <= st_d;
            pend_v_q     <= pend_v_d;
            pend_addr_q  <= pend_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_rd0_q   <= disp_rd0_d;
            disp_rd1_q   <= disp_rd1_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
endmodule
